// File: rtl/wr_fram_buf_ctrl.sv
// Frame write-buffer scheduler: packs 32-bit pixels into the RAM (1-cycle registered write) and bursts 128-bit beats to DDR.
// Pixels have no back-pressure (overflow drops words); DDR data uses valid/ready. Define WR_FRAM_OVF_CNT_EN for a drop counter.
module wr_fram_buf_ctrl #(
    parameter int BURST_LEN    = 16,
    parameter int FRAME_BEATS  = 259200,
    parameter int NUM_FRAMES   = 3,
    parameter int FRAME_BASE   = 0,
    parameter int FRAME_STRIDE = 262144,
    parameter int ADDR_W       = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [31:0]       pix_data,
    input  logic              pix_valid,
    output logic [31:0]       ram_wr_data,
    output logic [10:0]       ram_wr_addr,
    output logic              ram_wr_en,
    output logic [8:0]        ram_rd_addr,
    input  logic [127:0]      ram_rd_data,
    output logic              ddr_wr_req,
    output logic [ADDR_W-1:0] ddr_wr_addr,
    output logic [8:0]        ddr_wr_len,
    input  logic              ddr_wr_ack,
    output logic [127:0]      ddr_wdata,
    output logic              ddr_wdata_valid,
    input  logic              ddr_wdata_ready,
    output logic              ddr_wdata_last,
    output logic [1:0]        frame_idx,
    output logic              ovf,
    output logic [15:0]       ovf_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [11:0]         wp_q, wp_d;
    logic [9:0]          rp_q, rp_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   beat_ofs_q, beat_ofs_d;
    logic [ADDR_W-1:0]   fbase_q, fbase_d;
    logic [1:0]          fidx_q, fidx_d, fidx_nxt;
    logic                ovf_q, ovf_d;
    logic                wen_q;
    logic [10:0]         waddr_q;
    logic [31:0]         wdat_q;
    logic [8:0]          ra_q, ra_d;
    logic [8:0]          iss_q, iss_d;
    logic                inf_q, inf_d, inf_last_q, inf_last_d;
    logic                out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [127:0]        out_dat_q, out_dat_d;
    logic                skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
    logic [127:0]        skid_dat_q, skid_dat_d;

    logic [9:0]  level;
    logic [11:0] free_words;
    logic        wr_ok, drop, pop, issue, out_free, burst_done;
    logic        in_data, do_flush;
    logic [1:0]  entries;

    assign level      = wp_q[11:2] - rp_q;
    assign free_words = 12'd2048 - (wp_q - {rp_q, 2'b00});
    assign wr_ok      = pix_valid && (free_words != 12'd0) && !pend_q;
    assign drop       = pix_valid && !wr_ok;
    assign pop        = out_vld_q && ddr_wdata_ready;
    assign burst_done = pop && out_last_q;
    assign out_free   = !out_vld_q || ddr_wdata_ready;
    assign entries    = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, inf_q};
    // Output + skid give two slots; a read is only launched if its data is guaranteed a slot next cycle.
    assign issue      = in_data && (iss_q != 9'(BURST_LEN)) && ((entries - {1'b0, pop}) < 2'd2);
    assign fidx_nxt   = (fidx_q == 2'(NUM_FRAMES - 1)) ? 2'd0 : fidx_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q)
                    state_d = FLUSH;
                else if (level >= 10'(BURST_LEN) && beat_ofs_q < ADDR_W'(FRAME_BEATS))
                    state_d = REQ;
            end
            REQ:     if (ddr_wr_ack) state_d = DATA;
            DATA:    if (burst_done) state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ddr_wr_req = (state_q == REQ);
        in_data    = (state_q == DATA);
        do_flush   = (state_q == FLUSH);
    end

    always_comb begin
        wp_d        = wr_ok ? wp_q + 12'd1 : wp_q;
        rp_d        = pop ? rp_q + 10'd1 : rp_q;
        pend_d      = pend_q || frame_start;
        beat_ofs_d  = burst_done ? beat_ofs_q + ADDR_W'(BURST_LEN) : beat_ofs_q;
        fidx_d      = fidx_q;
        fbase_d     = fbase_q;
        ovf_d       = ovf_q || drop;
        ra_d        = in_data ? (issue ? ra_q + 9'd1 : ra_q) : rp_q[8:0];
        iss_d       = in_data ? (issue ? iss_q + 9'd1 : iss_q) : 9'd0;
        inf_d       = issue;
        inf_last_d  = issue && (iss_q == 9'(BURST_LEN - 1));
        out_vld_d   = out_vld_q;
        out_dat_d   = out_dat_q;
        out_last_d  = out_last_q;
        skid_vld_d  = skid_vld_q;
        skid_dat_d  = skid_dat_q;
        skid_last_d = skid_last_q;

        if (out_free) begin
            if (skid_vld_q) begin
                out_vld_d   = 1'b1;
                out_dat_d   = skid_dat_q;
                out_last_d  = skid_last_q;
                skid_vld_d  = inf_q;
                skid_dat_d  = ram_rd_data;
                skid_last_d = inf_last_q;
            end else begin
                out_vld_d  = inf_q;
                out_last_d = inf_last_q;
                if (inf_q) out_dat_d = ram_rd_data;
            end
        end else if (inf_q) begin
            skid_vld_d  = 1'b1;
            skid_dat_d  = ram_rd_data;
            skid_last_d = inf_last_q;
        end

        // Partial data is discarded; a frame_start landing in this cycle starts the next flush.
        if (do_flush) begin
            wp_d       = 12'd0;
            rp_d       = 10'd0;
            beat_ofs_d = '0;
            fidx_d     = fidx_nxt;
            fbase_d    = ADDR_W'(FRAME_BASE + FRAME_STRIDE * int'(fidx_nxt));
            pend_d     = frame_start;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            pend_q      <= 1'b0;
            beat_ofs_q  <= '0;
            fbase_q     <= '0;
            fidx_q      <= '0;
            ovf_q       <= 1'b0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdat_q      <= '0;
            ra_q        <= '0;
            iss_q       <= '0;
            inf_q       <= 1'b0;
            inf_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            out_last_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_dat_q  <= '0;
            skid_last_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            pend_q      <= pend_d;
            beat_ofs_q  <= beat_ofs_d;
            fbase_q     <= fbase_d;
            fidx_q      <= fidx_d;
            ovf_q       <= ovf_d;
            wen_q       <= wr_ok;
            if (wr_ok) begin
                waddr_q <= wp_q[10:0];
                wdat_q  <= pix_data;
            end
            ra_q        <= ra_d;
            iss_q       <= iss_d;
            inf_q       <= inf_d;
            inf_last_q  <= inf_last_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_last_q  <= out_last_d;
            skid_vld_q  <= skid_vld_d;
            skid_dat_q  <= skid_dat_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign ram_wr_en       = wen_q;
    assign ram_wr_addr     = waddr_q;
    assign ram_wr_data     = wdat_q;
    assign ram_rd_addr     = ra_q;
    assign ddr_wr_addr     = fbase_q + beat_ofs_q;
    assign ddr_wr_len      = 9'(BURST_LEN - 1);
    assign ddr_wdata       = out_dat_q;
    assign ddr_wdata_valid = out_vld_q;
    assign ddr_wdata_last  = out_last_q;
    assign frame_idx       = fidx_q;
    assign ovf             = ovf_q;

`ifdef WR_FRAM_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    assign ovf_cnt_d = (drop && ovf_cnt_q != 16'hFFFF) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_wr_fram_buf_ctrl.sv
// Bench for wr_fram_buf_ctrl: table of stimulus rows plus hand sequences, scored against a queue-based model of buffer contents.
module tb_wr_fram_buf_ctrl;
    localparam int BL = 16, FB = 64, NF = 3, FS = 1024;
`ifdef WR_FRAM_OVF_CNT_EN
    localparam int OCNT_EN = 1;
`else
    localparam int OCNT_EN = 0;
`endif

    logic         clk = 1'b0;
    logic         rst, frame_start, pix_valid, ram_wr_en, ddr_wr_req, ddr_wr_ack;
    logic [31:0]  pix_data, ram_wr_data;
    logic [10:0]  ram_wr_addr;
    logic [8:0]   ram_rd_addr, ddr_wr_len;
    logic [127:0] ram_rd_data, ddr_wdata;
    logic [27:0]  ddr_wr_addr;
    logic         ddr_wdata_valid, ddr_wdata_ready, ddr_wdata_last, ovf;
    logic [1:0]   frame_idx;
    logic [15:0]  ovf_cnt;

    always #5 clk = ~clk;

    wr_fram_buf_ctrl #(.BURST_LEN(BL), .FRAME_BEATS(FB), .NUM_FRAMES(NF), .FRAME_BASE(0),
                       .FRAME_STRIDE(FS), .ADDR_W(28)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_data(pix_data), .pix_valid(pix_valid),
        .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .ddr_wr_req(ddr_wr_req),
        .ddr_wr_addr(ddr_wr_addr), .ddr_wr_len(ddr_wr_len), .ddr_wr_ack(ddr_wr_ack),
        .ddr_wdata(ddr_wdata), .ddr_wdata_valid(ddr_wdata_valid), .ddr_wdata_ready(ddr_wdata_ready),
        .ddr_wdata_last(ddr_wdata_last), .frame_idx(frame_idx), .ovf(ovf), .ovf_cnt(ovf_cnt));

    // Dual-width RAM: 2048x32 write port, 512x128 read port with one-cycle read latency.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= {mem[{ram_rd_addr, 2'd3}], mem[{ram_rd_addr, 2'd2}],
                        mem[{ram_rd_addr, 2'd1}], mem[{ram_rd_addr, 2'd0}]};
    end

    int errs = 0, checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: queue of buffered words, counts of accepted words/beats, frame bookkeeping.
    logic [31:0]  wq[$];
    int           words_acc, beats_acc, dropped, wr_seen, reqs_seen, beats_seen;
    int           burst_beat, bursts_in_frame, fidx_m;
    bit           mon_en = 1'b0;
    bit           st_stall, st_req, st_last;
    logic [127:0] st_dat;
    logic [27:0]  st_addr;

    int ack_dly = 0, rdy_mode = 0, req_wait = 0;
    bit ack_en = 1'b0;

    task automatic model_reset();
        wq.delete();
        words_acc = 0; beats_acc = 0; dropped = 0; wr_seen = 0; reqs_seen = 0; beats_seen = 0;
        burst_beat = 0; bursts_in_frame = 0; fidx_m = 0; st_stall = 1'b0; st_req = 1'b0;
    endtask

    task automatic model_flush();
        wq.delete();
        words_acc = 0; beats_acc = 0; burst_beat = 0; bursts_in_frame = 0;
        fidx_m = (fidx_m + 1) % NF;
    endtask

    always @(negedge clk) begin : monitor
        logic [127:0] e;
        if (!rst && mon_en) begin
            if (pix_valid) begin
                if (words_acc - 4 * beats_acc < 2048) begin
                    wq.push_back(pix_data);
                    words_acc++;
                end else dropped++;
            end
            if (ram_wr_en) wr_seen++;
            if (st_stall) begin
                chk("stall_valid", ddr_wdata_valid, 1);
                chk("stall_data", ddr_wdata, st_dat);
                chk("stall_last", ddr_wdata_last, st_last);
            end
            if (st_req) begin
                chk("req_hold", ddr_wr_req, 1);
                chk("req_addr_hold", ddr_wr_addr, st_addr);
            end
            if (rdy_mode == 0 && burst_beat != 0) chk("no_bubble", ddr_wdata_valid, 1);
            st_stall = ddr_wdata_valid && !ddr_wdata_ready;
            st_dat   = ddr_wdata;
            st_last  = ddr_wdata_last;
            st_req   = ddr_wr_req && !ddr_wr_ack;
            st_addr  = ddr_wr_addr;
            if (ddr_wr_req && ddr_wr_ack) begin
                chk("req_addr", ddr_wr_addr, fidx_m * FS + bursts_in_frame * BL);
                chk("req_within_frame", bursts_in_frame < FB / BL, 1);
                bursts_in_frame++;
                reqs_seen++;
            end
            if (ddr_wdata_valid && ddr_wdata_ready) begin
                chk("beat_available", wq.size() >= 4, 1);
                if (wq.size() >= 4) begin
                    e[31:0]   = wq.pop_front();
                    e[63:32]  = wq.pop_front();
                    e[95:64]  = wq.pop_front();
                    e[127:96] = wq.pop_front();
                    chk("beat_data", ddr_wdata, e);
                end
                chk("beat_last", ddr_wdata_last, burst_beat == BL - 1);
                burst_beat = (burst_beat == BL - 1) ? 0 : burst_beat + 1;
                beats_acc++;
                beats_seen++;
            end
        end
    end

    always @(posedge clk) begin : drivers
        #1;
        if (ddr_wr_req && ack_en) begin
            if (req_wait >= ack_dly) ddr_wr_ack = 1'b1;
            else begin
                ddr_wr_ack = 1'b0;
                req_wait++;
            end
        end else begin
            ddr_wr_ack = 1'b0;
            req_wait = 0;
        end
        case (rdy_mode)
            0:       ddr_wdata_ready = 1'b1;
            1:       ddr_wdata_ready = ~ddr_wdata_ready;
            default: ddr_wdata_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, ram_wr_en, 0);
        chk({tag, "_wr_addr"}, ram_wr_addr, 0);
        chk({tag, "_wr_data"}, ram_wr_data, 0);
        chk({tag, "_rd_addr"}, ram_rd_addr, 0);
        chk({tag, "_req"}, ddr_wr_req, 0);
        chk({tag, "_ddr_addr"}, ddr_wr_addr, 0);
        chk({tag, "_len"}, ddr_wr_len, BL - 1);
        chk({tag, "_wdata"}, ddr_wdata, 0);
        chk({tag, "_valid"}, ddr_wdata_valid, 0);
        chk({tag, "_last"}, ddr_wdata_last, 0);
        chk({tag, "_frame_idx"}, frame_idx, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_ovf_cnt"}, ovf_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic settle();
        int q = 0, t = 0;
        while (q < 20 && t < 5000) begin
            @(posedge clk); #1;
            t++;
            if (!ddr_wdata_valid && !(ddr_wr_req && ack_en)) q++;
            else q = 0;
        end
        chk("settle_timeout", q >= 20, 1);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic new_frame();
        pulse_fs();
        settle();
        model_flush();
    endtask

    task automatic push(input int n, input bit gaps, input bit rnd, input int base);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                @(posedge clk); #1;
            end
            pix_valid = 1'b1;
            pix_data  = rnd ? $urandom : 32'(base + i);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_beats(input int k);
        int t = 0;
        while (beats_seen < k && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_beats_timeout", beats_seen >= k, 1);
    endtask

    typedef struct {
        int n; int ack_dly; bit ack_en; int rdy_mode; bit gaps; bit rnd;
        int exp_reqs; int exp_beats; int exp_wr; bit exp_ovf; int exp_ocnt;
    } row_t;
    row_t rows[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rows[0] = '{64,   2,   1'b1, 0, 1'b0, 1'b0, 1, 16, 64,   1'b0, 0};
        rows[1] = '{64,   2,   1'b1, 1, 1'b0, 1'b0, 1, 16, 64,   1'b0, 0};
        rows[2] = '{320,  300, 1'b1, 0, 1'b0, 1'b0, 4, 64, 320,  1'b0, 0};
        rows[3] = '{2049, 0,   1'b0, 0, 1'b0, 1'b0, 0, 0,  2048, 1'b1, 1};
        rows[4] = '{200,  1,   1'b1, 2, 1'b1, 1'b1, 3, 48, 200,  1'b0, 0};

        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        ddr_wr_ack = 1'b0; ddr_wdata_ready = 1'b0;
        #1;
        chk_reset_outputs("reset");
        mon_en = 1'b1;

        foreach (rows[r]) begin
            do_reset();
            ack_en = rows[r].ack_en; ack_dly = rows[r].ack_dly; rdy_mode = rows[r].rdy_mode;
            new_frame();
            chk($sformatf("row%0d_frame_idx", r), frame_idx, 1);
            push(rows[r].n, rows[r].gaps, rows[r].rnd, 0);
            settle();
            chk($sformatf("row%0d_reqs", r), reqs_seen, rows[r].exp_reqs);
            chk($sformatf("row%0d_beats", r), beats_seen, rows[r].exp_beats);
            chk($sformatf("row%0d_ram_writes", r), wr_seen, rows[r].exp_wr);
            chk($sformatf("row%0d_ovf", r), ovf, rows[r].exp_ovf);
            chk($sformatf("row%0d_ovf_cnt", r), ovf_cnt, OCNT_EN * rows[r].exp_ocnt);
        end

        // frame_start mid-burst: burst finishes, second burst is skipped, frames rotate 1 -> 2 -> 0.
        do_reset();
        ack_en = 1'b1; ack_dly = 200; rdy_mode = 0;
        new_frame();
        push(128, 1'b0, 1'b0, 1000);
        wait_beats(1);
        pulse_fs();
        settle();
        chk("fs_mid_reqs", reqs_seen, 1);
        chk("fs_mid_beats", beats_seen, 16);
        chk("fs_mid_frame_idx", frame_idx, 2);
        model_flush();
        ack_dly = 2;
        push(64, 1'b0, 1'b0, 2000);
        settle();
        chk("frame2_reqs", reqs_seen, 2);
        new_frame();
        chk("wrap_frame_idx", frame_idx, 0);
        push(64, 1'b0, 1'b0, 3000);
        settle();
        chk("frame0_reqs", reqs_seen, 3);
        chk("frame0_beats", beats_seen, 48);

        // Reset in the middle of a burst.
        do_reset();
        ack_en = 1'b1; ack_dly = 2; rdy_mode = 0;
        new_frame();
        push(64, 1'b0, 1'b0, 4000);
        wait_beats(5);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        push(32, 1'b0, 1'b0, 5000);
        settle();
        chk("midrst_no_req", reqs_seen, 0);
        push(32, 1'b0, 1'b0, 5032);
        settle();
        chk("midrst_reqs", reqs_seen, 1);
        chk("midrst_beats", beats_seen, 16);
        chk("midrst_frame_idx", frame_idx, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
